// File: rtl/motion_pkg.sv
// Shared definitions for the sprite motion controller: HID keycodes,
// FSM state encoding, datapath width and the velocity saturation helper.
package motion_pkg;

  // USB HID usage IDs for the movement keys
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  // Width of the signed position arithmetic
  localparam int unsigned CW = 12;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    STEP,
    CLAMP,
    DONE
  } state_t;

  // Clip a signed SoC velocity to [0, vmax]; a negative speed means "stand still"
  function automatic logic signed [CW-1:0] sat_speed(
    input logic signed [31:0] v,
    input logic signed [31:0] vmax
  );
    logic signed [CW-1:0] r;
    if (v < 0)
      r = '0;
    else if (v > vmax)
      r = vmax[CW-1:0];
    else
      r = v[CW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/key_dir_decode.sv
// Maps two HID keycodes onto per-axis directions (-1, 0, +1).
// Opposing keys on one axis cancel to 0.
module key_dir_decode
  import motion_pkg::*;
(
  input  logic [15:0]       keycode,
  output logic signed [1:0] dir_x,
  output logic signed [1:0] dir_y
);

  logic [7:0] k0;
  logic [7:0] k1;
  logic       key_l;
  logic       key_r;
  logic       key_u;
  logic       key_d;

  assign k0 = keycode[7:0];
  assign k1 = keycode[15:8];

  // A key counts as pressed if it appears in either report byte
  always_comb begin
    key_l = (k0 == KEY_A) || (k1 == KEY_A);
    key_r = (k0 == KEY_D) || (k1 == KEY_D);
    key_u = (k0 == KEY_W) || (k1 == KEY_W);
    key_d = (k0 == KEY_S) || (k1 == KEY_S);
  end

  // Direction per axis; both or neither key on an axis gives 0
  always_comb begin
    dir_x = 2'sd0;
    dir_y = 2'sd0;
    if (key_r && !key_l)
      dir_x = 2'sd1;
    else if (key_l && !key_r)
      dir_x = -2'sd1;
    if (key_d && !key_u)
      dir_y = 2'sd1;
    else if (key_u && !key_d)
      dir_y = -2'sd1;
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position update: on frame_start the keyboard state and
// SoC velocities are latched, then decoded, stepped and clamped to the
// visible area over a fixed IDLE-DECODE-STEP-CLAMP-DONE sequence.
module sprite_motion_ctrl
  import motion_pkg::*;
#(
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 639,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 479,
  parameter int SIZE    = 4,
  parameter int X_RESET = 320,
  parameter int Y_RESET = 240,
  parameter int VEL_MAX = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic [15:0]        keycode,
  input  logic signed [31:0] x_velocity,
  input  logic signed [31:0] y_velocity,
  output logic [9:0]         pos_x,
  output logic [9:0]         pos_y,
  output logic [1:0]         hit,
  output logic               busy,
  output logic               update_done,
  output logic               overrun
);

  localparam logic signed [CW-1:0] X_LO = CW'(X_MIN + SIZE);
  localparam logic signed [CW-1:0] X_HI = CW'(X_MAX - SIZE);
  localparam logic signed [CW-1:0] Y_LO = CW'(Y_MIN + SIZE);
  localparam logic signed [CW-1:0] Y_HI = CW'(Y_MAX - SIZE);
  localparam logic signed [CW:0]   SUM_MAX = 13'sd2047;
  localparam logic signed [CW:0]   SUM_MIN = -13'sd2048;

  state_t state;
  state_t state_nxt;

  // Inputs captured at frame_start
  logic [15:0]        key_q;
  logic signed [31:0] xv_q;
  logic signed [31:0] yv_q;

  // DECODE results
  logic signed [1:0]    dir_x;
  logic signed [1:0]    dir_y;
  logic signed [1:0]    dir_x_q;
  logic signed [1:0]    dir_y_q;
  logic signed [CW-1:0] spd_x_q;
  logic signed [CW-1:0] spd_y_q;

  // STEP results
  logic signed [CW-1:0] nx_q;
  logic signed [CW-1:0] ny_q;

  // CLAMP results
  logic [9:0] cx;
  logic [9:0] cy;
  logic       hx;
  logic       hy;

  key_dir_decode u_key_dir_decode (
    .keycode (key_q),
    .dir_x   (dir_x),
    .dir_y   (dir_y)
  );

  // pos + dir*spd in one extra bit, then pinned to the CW-bit signed range
  function automatic logic signed [CW-1:0] step_axis(
    input logic [9:0]           p,
    input logic signed [1:0]    d,
    input logic signed [CW-1:0] s
  );
    logic signed [CW:0]   pe;
    logic signed [CW:0]   se;
    logic signed [CW:0]   sum;
    logic signed [CW-1:0] r;
    pe = {3'b000, p};
    se = {s[CW-1], s};
    case (d)
      2'sd1:   sum = pe + se;
      -2'sd1:  sum = pe - se;
      default: sum = pe;
    endcase
    if (sum > SUM_MAX)
      r = SUM_MAX[CW-1:0];
    else if (sum < SUM_MIN)
      r = SUM_MIN[CW-1:0];
    else
      r = sum[CW-1:0];
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and status outputs; only IDLE waits, all others advance
  always_comb begin
    state_nxt   = state;
    busy        = 1'b1;
    update_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (frame_start)
          state_nxt = DECODE;
      end
      DECODE: state_nxt = STEP;
      STEP:   state_nxt = CLAMP;
      CLAMP:  state_nxt = DONE;
      DONE: begin
        update_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clamp the stepped position to the screen area minus the sprite half-size
  always_comb begin
    cx = nx_q[9:0];
    cy = ny_q[9:0];
    hx = 1'b0;
    hy = 1'b0;
    if (nx_q < X_LO) begin
      cx = X_LO[9:0];
      hx = 1'b1;
    end else if (nx_q > X_HI) begin
      cx = X_HI[9:0];
      hx = 1'b1;
    end
    if (ny_q < Y_LO) begin
      cy = Y_LO[9:0];
      hy = 1'b1;
    end else if (ny_q > Y_HI) begin
      cy = Y_HI[9:0];
      hy = 1'b1;
    end
  end

  // Datapath pipeline; the visible position is only written on entry to DONE,
  // so a reset part-way through leaves no partial update behind
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q   <= '0;
      xv_q    <= '0;
      yv_q    <= '0;
      dir_x_q <= '0;
      dir_y_q <= '0;
      spd_x_q <= '0;
      spd_y_q <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      pos_x   <= 10'(X_RESET);
      pos_y   <= 10'(Y_RESET);
      hit     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            key_q <= keycode;
            xv_q  <= x_velocity;
            yv_q  <= y_velocity;
          end
        end
        DECODE: begin
          dir_x_q <= dir_x;
          dir_y_q <= dir_y;
          spd_x_q <= sat_speed(xv_q, VEL_MAX);
          spd_y_q <= sat_speed(yv_q, VEL_MAX);
        end
        STEP: begin
          nx_q <= step_axis(pos_x, dir_x_q, spd_x_q);
          ny_q <= step_axis(pos_y, dir_y_q, spd_y_q);
        end
        CLAMP: begin
          pos_x <= cx;
          pos_y <= cy;
          hit   <= {hy, hx};
        end
        default: ;
      endcase
    end
  end

  // Sticky flag for frame_start pulses dropped while an update is in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      overrun <= 1'b0;
    else if (frame_start && (state != IDLE))
      overrun <= 1'b1;
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: expected positions are queued
// when a frame is issued and compared when update_done fires.
module tb_sprite_motion_ctrl;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               frame_start;
  logic [15:0]        keycode;
  logic signed [31:0] x_velocity;
  logic signed [31:0] y_velocity;
  logic [9:0]         pos_x;
  logic [9:0]         pos_y;
  logic [1:0]         hit;
  logic               busy;
  logic               update_done;
  logic               overrun;

  always #5 clk = ~clk;

  sprite_motion_ctrl #(
    .X_MIN   (0),
    .X_MAX   (639),
    .Y_MIN   (0),
    .Y_MAX   (479),
    .SIZE    (4),
    .X_RESET (320),
    .Y_RESET (240),
    .VEL_MAX (15)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .keycode     (keycode),
    .x_velocity  (x_velocity),
    .y_velocity  (y_velocity),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .hit         (hit),
    .busy        (busy),
    .update_done (update_done),
    .overrun     (overrun)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  typedef struct {
    int x;
    int y;
    int h;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mx = 320;
  int   my = 240;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit has_key(input logic [15:0] k, input logic [7:0] c);
    return (k[7:0] == c) || (k[15:8] == c);
  endfunction

  function automatic int axis_model(input int p, input bit dn, input bit up, input int v,
                                    input int lo, input int hi, output bit h);
    int d;
    int s;
    int n;
    d = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
    s = (v < 0) ? 0 : ((v > 15) ? 15 : v);
    n = p + d * s;
    h = 1'b0;
    if (n < lo) begin
      n = lo;
      h = 1'b1;
    end else if (n > hi) begin
      n = hi;
      h = 1'b1;
    end
    return n;
  endfunction

  // Called right after a negedge with the DUT idle; returns one negedge later
  task automatic pulse_frame(input logic [15:0] k, input int xv, input int yv);
    exp_t e;
    bit   hx;
    bit   hy;
    e.x = axis_model(mx, has_key(k, 8'h04), has_key(k, 8'h07), xv, 4, 635, hx);
    e.y = axis_model(my, has_key(k, 8'h1A), has_key(k, 8'h16), yv, 4, 475, hy);
    e.h = (hy ? 2 : 0) + (hx ? 1 : 0);
    e.cyc = cyc + 4;
    mx = e.x;
    my = e.y;
    sb.push_back(e);
    keycode     = k;
    x_velocity  = xv;
    y_velocity  = yv;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check_eq("busy_after_accept", busy, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0 && busy == 1'b0) break;
      @(negedge clk);
    end
    check_eq("scoreboard_drained", sb.size(), 0);
    check_eq("idle_after_update", busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pos_x"}, pos_x, 320);
    check_eq({tag, "_pos_y"}, pos_y, 240);
    check_eq({tag, "_hit"}, hit, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_update_done"}, update_done, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (reset_n === 1'b1 && update_done === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("spurious_update_done", update_done, 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("pos_x", pos_x, mon_e.x);
        check_eq("pos_y", pos_y, mon_e.y);
        check_eq("hit", hit, mon_e.h);
        check_eq("latency_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    frame_start = 1'b0;
    keycode     = '0;
    x_velocity  = '0;
    y_velocity  = '0;
    #12;
    check_reset_vals("reset");
    repeat (2) @(negedge clk);
    check_reset_vals("reset_hold");

    // Release and issue a frame on the very first edge
    reset_n = 1'b1;
    pulse_frame(16'h0007, 3, 0);
    wait_idle();

    // Opposing keys cancel, then single-axis and combined moves
    pulse_frame(16'h0704, 5, 0);
    wait_idle();
    pulse_frame(16'h0016, 0, 7);
    wait_idle();
    pulse_frame(16'h1A00, 0, 20);
    wait_idle();
    pulse_frame(16'h0004, -4, 0);
    wait_idle();
    pulse_frame(16'h1A07, 2, 2);
    wait_idle();
    pulse_frame(16'h0000, 9, 9);
    wait_idle();

    // Walk right to 632, then overshoot with a saturated speed
    while (mx + 15 <= 632) begin
      pulse_frame(16'h0007, 15, 0);
      wait_idle();
    end
    if (mx < 632) begin
      pulse_frame(16'h0007, 632 - mx, 0);
      wait_idle();
    end
    pulse_frame(16'h0007, 100, 0);
    wait_idle();

    // Run into the top edge
    for (int i = 0; i < 18; i++) begin
      pulse_frame(16'h001A, 0, 15);
      wait_idle();
    end

    // Negative velocity stands still; a frame_start during DECODE is dropped
    check_eq("overrun_before", overrun, 0);
    pulse_frame(16'h001A, 0, -8);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check_eq("overrun_set", overrun, 1);
    wait_idle();
    check_eq("overrun_held", overrun, 1);
    pulse_frame(16'h0016, 0, 3);
    wait_idle();
    check_eq("overrun_sticky", overrun, 1);

    // Reset in the middle of an update
    pulse_frame(16'h0007, 5, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    sb.delete();
    mx = 320;
    my = 240;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("no_done_in_reset", update_done, 0);
      check_eq("pos_x_in_reset", pos_x, 320);
    end
    reset_n = 1'b1;
    pulse_frame(16'h0016, 0, 15);
    wait_idle();
    check_eq("overrun_after_reset", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 SHALL have parameter X_MIN, default 0, left screen edge in pixels.
REQ-002 SHALL have parameter X_MAX, default 639, right screen edge in pixels.
REQ-003 SHALL have parameter Y_MIN, default 0, top screen edge in pixels.
REQ-004 SHALL have parameter Y_MAX, default 479, bottom screen edge in pixels.
REQ-005 SHALL have parameter SIZE, default 4, sprite half-size in pixels.
REQ-006 SHALL have parameters X_RESET, default 320, and Y_RESET, default 240, giving the reset position.
REQ-007 SHALL have parameter VEL_MAX, default 15, speed ceiling in pixels/frame.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-010 SHALL have port frame_start, input, 1 bit: one-cycle pulse at the start of each frame.
REQ-011 SHALL have port keycode, input, 16 bits: two USB HID keycodes, [7:0] and [15:8], from the SoC export.
REQ-012 SHALL have port x_velocity, input, 32 bits: signed x speed from the SoC export.
REQ-013 SHALL have port y_velocity, input, 32 bits: signed y speed from the SoC export.
REQ-014 SHALL have port pos_x, output, 10 bits: sprite centre x.
REQ-015 SHALL have port pos_y, output, 10 bits: sprite centre y.
REQ-016 SHALL have port hit, output, 2 bits: [0] x clamp occurred, [1] y clamp occurred, on the last update.
REQ-017 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-018 SHALL have port update_done, output, 1 bit: one-cycle pulse when the new position is valid.
REQ-019 SHALL have port overrun, output, 1 bit: sticky flag for a frame_start dropped while busy.

Function
REQ-020 SHALL implement FSM states IDLE, DECODE, STEP, CLAMP and DONE; DONE always returns to IDLE; every other state advances unconditionally.
REQ-021 SHALL, in IDLE on frame_start, latch keycode, x_velocity and y_velocity, then enter DECODE.
REQ-022 SHALL decode direction from either byte: A=0x04 gives dx-1, D=0x07 gives dx+1, W=0x1A gives dy-1, S=0x16 gives dy+1; any other code gives 0.
REQ-023 SHALL set the axis direction to 0 when opposing keys on that axis are both pressed.
REQ-024 SHALL, in DECODE, saturate each velocity: negative gives 0, above VEL_MAX gives VEL_MAX, otherwise the value is kept.
REQ-025 SHALL, in STEP, form next = pos + dir*speed in 12-bit signed arithmetic with no wrap-around.
REQ-026 SHALL, in CLAMP, limit next_x to [X_MIN+SIZE, X_MAX-SIZE] and next_y to [Y_MIN+SIZE, Y_MAX-SIZE].
REQ-027 SHALL, in CLAMP, set each hit bit iff clamping changed that axis value.
REQ-028 SHALL register pos_x, pos_y and hit on the edge that enters DONE, and hold them at all other times.
REQ-029 SHALL assert update_done for exactly the DONE cycle, giving a latency of 4 cycles from a frame_start at cycle N to update_done at cycle N+4.
REQ-030 SHALL ignore a frame_start that arrives when the FSM is not IDLE, and shall set overrun, which stays set until reset.
REQ-031 SHALL accept a frame_start that arrives in the cycle after DONE.
REQ-032 SHALL leave pos unchanged, with hit=00 and update_done still pulsed, when no movement key is pressed.

Reset
REQ-033 SHALL, while reset_n=0 and regardless of clk, force state=IDLE, pos_x=X_RESET, pos_y=Y_RESET, hit=00, busy=0, update_done=0, overrun=0, and clear all latched inputs.
REQ-034 SHALL, on reset during any state, abort the update with no partial position written.
REQ-035 SHALL, after deassertion of reset_n, accept a frame_start on the first clk edge.

Structure
REQ-036 SHALL place the keycode constants (KEY_W, KEY_A, KEY_S, KEY_D) and the FSM state enum in a shared package, motion_pkg.
REQ-037 SHALL implement the key-to-direction mapping and conflict cancellation of REQ-022 and REQ-023 in one combinational sub-module, key_dir_decode.

Verification
REQ-038 SHALL test: reset, then frame_start with keycode=0x0007 and x_velocity=3 -> at N+4, update_done=1, pos_x=323, pos_y=240, hit=00.
REQ-039 SHALL test: keycode=0x0704 (A+D) with x_velocity=5 -> pos_x unchanged, hit=00.
REQ-040 SHALL test: pos_x=632, keycode=0x0007, x_velocity=100 -> speed saturates to 15, pos_x=635, hit[0]=1.
REQ-041 SHALL test: keycode=0x001A with y_velocity=-8 -> pos_y unchanged; a second frame_start issued in DECODE -> ignored, overrun=1.
REQ-042 SHALL test: reset_n pulsed low during STEP -> pos=(320,240), update_done is never asserted, and busy=0 immediately.
